// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys fetched by index.
// Latency: out_valid rises 11 edges after the accept edge; one block every 12 cycles back-to-back.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module aes_decrypt #(
   parameter int NR = 10
) (
   input  logic              eph1,
   input  logic              reset_n,
   input  logic [255:0][7:0] INV_SBOX,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0][7:0]  ct_in,
   output logic [3:0]        rk_idx,
   input  logic [127:0]      rk_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0][7:0]  pt_out
);

   localparam logic [3:0] RK_LAST  = 4'(NR);
   localparam logic [3:0] RC_FIRST = 4'(NR - 1);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [15:0][7:0] blk_q, blk_d;
   logic [3:0]       rc_q, rc_d;

   logic [15:0][7:0] isr, isb, ark, imc;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // GF(2^8) multiply by a 4-bit constant (09, 0b, 0d, 0e are all that is needed)
   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] b2, b4, b8;
      b2 = xtime(b);
      b4 = xtime(b2);
      b8 = xtime(b4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
   endfunction

   // Row r rotated right by r; byte 15 is row 0 of column 0
   function automatic logic [15:0][7:0] inv_shift_rows(input logic [15:0][7:0] x);
      logic [15:0][7:0] y;
      y[15] = x[15]; y[14] = x[2];  y[13] = x[5];  y[12] = x[8];
      y[11] = x[11]; y[10] = x[14]; y[9]  = x[1];  y[8]  = x[4];
      y[7]  = x[7];  y[6]  = x[10]; y[5]  = x[13]; y[4]  = x[0];
      y[3]  = x[3];  y[2]  = x[6];  y[1]  = x[9];  y[0]  = x[12];
      return y;
   endfunction

   function automatic logic [15:0][7:0] inv_mix_columns(input logic [15:0][7:0] x);
      logic [15:0][7:0] y;
      logic [7:0]       a, b, c, d;
      for (int col = 0; col < 4; col++) begin
         a = x[15 - 4*col];
         b = x[14 - 4*col];
         c = x[13 - 4*col];
         d = x[12 - 4*col];
         y[15 - 4*col] = gm(a, 4'he) ^ gm(b, 4'hb) ^ gm(c, 4'hd) ^ gm(d, 4'h9);
         y[14 - 4*col] = gm(a, 4'h9) ^ gm(b, 4'he) ^ gm(c, 4'hb) ^ gm(d, 4'hd);
         y[13 - 4*col] = gm(a, 4'hd) ^ gm(b, 4'h9) ^ gm(c, 4'he) ^ gm(d, 4'hb);
         y[12 - 4*col] = gm(a, 4'hb) ^ gm(b, 4'hd) ^ gm(c, 4'h9) ^ gm(d, 4'he);
      end
      return y;
   endfunction

   // Round datapath: shared by ROUND (with mix) and FINAL (without mix)
   always_comb begin
      isr = inv_shift_rows(blk_q);
      for (int i = 0; i < 16; i++) begin
         isb[i] = INV_SBOX[~isr[i]];
      end
      ark = isb ^ rk_in;
      imc = inv_mix_columns(ark);
   end

   // Next-state and output decode; outputs are pure functions of the current state
   always_comb begin
      fsm_d     = fsm_q;
      blk_d     = blk_q;
      rc_d      = rc_q;
      in_ready  = 1'b0;
      rk_idx    = 4'd0;
      out_valid = 1'b0;
      pt_out    = '0;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            rk_idx   = RK_LAST;
            if (in_valid) begin
               blk_d = ct_in ^ rk_in;
               rc_d  = RC_FIRST;
               fsm_d = ROUND;
            end
         end
         ROUND: begin
            rk_idx = rc_q;
            blk_d  = imc;
            rc_d   = rc_q - 4'd1;
            if (rc_q == 4'd1) begin
               fsm_d = FINAL;
            end
         end
         FINAL: begin
            rk_idx = 4'd0;
            blk_d  = ark;
            fsm_d  = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            pt_out    = blk_q;
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State registers; reset aborts any block in flight
   always_ff @(posedge eph1 or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q <= IDLE;
         blk_q <= '0;
         rc_q  <= 4'd0;
      end else begin
         fsm_q <= fsm_d;
         blk_q <= blk_d;
         rc_q  <= rc_d;
      end
   end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 SHALL have parameter: NR, 10, number of cipher rounds; only 10 (AES-128) is supported.
REQ-002 SHALL have ports eph1  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have ports reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports INV_SBOX  input  [255:0][7:0]  inverse S-box; byte value b maps to INV_SBOX[255-b].
REQ-005 SHALL have ports in_valid  input  1  ciphertext offered.
REQ-006 SHALL have ports in_ready  output  1  block can accept ciphertext.
REQ-007 SHALL have ports ct_in  input  [15:0][7:0]  ciphertext; byte 15 is first byte; column-major, column 0 = bytes 15..12.
REQ-008 SHALL have ports rk_idx  output  [3:0]  round-key index requested this cycle.
REQ-009 SHALL have ports rk_in  input  [127:0]  round key rk_idx; same-cycle combinational supply from the key store.
REQ-010 SHALL have ports out_valid  output  1  plaintext valid.
REQ-011 SHALL have ports out_ready  input  1  consumer takes plaintext.
REQ-012 SHALL have ports pt_out  output  [15:0][7:0]  plaintext, same byte order as ct_in.

Function
REQ-013 SHALL implement FSM states IDLE, ROUND, FINAL, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept = in_valid & in_ready.
REQ-015 SHALL in IDLE drive rk_idx=10 and, on accept, load state <= ct_in ^ rk_in, set round counter rc=9, go to ROUND.
REQ-016 SHALL in ROUND drive rk_idx=rc and update state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_in); decrement rc; leave for FINAL after rc=1 is processed.
REQ-017 SHALL in FINAL drive rk_idx=0, update state <= InvSubBytes(InvShiftRows(state)) ^ rk_in, and go to DONE.
REQ-018 SHALL define InvShiftRows y from x as y15=x15, y14=x2, y13=x5, y12=x8, y11=x11, y10=x14, y9=x1, y8=x4, y7=x7, y6=x10, y5=x13, y4=x0, y3=x3, y2=x6, y1=x9, y0=x12.
REQ-019 SHALL compute InvMixColumns per column (a,b,c,d = bytes top to bottom) with coefficient rows {0e,0b,0d,09} rotated right each row, using GF(2^8) reduction polynomial 0x11b and XOR addition.
REQ-020 SHALL assert out_valid only in DONE, with pt_out = state; pt_out SHALL be zero in all other states.
REQ-021 SHALL hold out_valid and pt_out stable in DONE while out_ready=0, and go to IDLE on out_valid & out_ready.
REQ-022 SHALL have fixed latency: out_valid rises exactly 11 rising edges after the accept edge (1 load + 9 ROUND + 1 FINAL).
REQ-023 SHALL ignore in_valid and ct_in in ROUND, FINAL and DONE; no ciphertext is dropped, because in_ready=0 there.
REQ-024 SHALL not accept new ciphertext in the DONE-to-IDLE cycle; the earliest next accept is the edge after the return to IDLE.
REQ-025 SHALL drive rk_idx=0 in DONE.
REQ-026 SHALL sample rk_in only in the cycle its index is driven.

Reset
REQ-027 SHALL on reset_n=0, asynchronously go to IDLE, with state=0, rc=0, out_valid=0, pt_out=0, in_ready=1 and rk_idx=10.
REQ-028 SHALL, on reset asserted mid-operation (any state), abort the block; no out_valid SHALL follow, and the first edge after release behaves as IDLE.

Verification
REQ-029 SHALL pass: key 000102030405060708090a0b0c0d0e0f (rk10=13111d7fe3944a17f307a78b4d2b30c5), ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt_out 00112233445566778899aabbccddeeff, out_valid 11 edges after accept.
REQ-030 SHALL pass: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734; rk_idx sequence observed 10,9,...,1,0.
REQ-031 SHALL pass backpressure: out_ready=0 for 5 cycles after out_valid -> pt_out held constant, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-032 SHALL pass busy input: in_valid held high with a different ct during ROUND -> ignored, and the first result is unchanged.
REQ-033 SHALL pass reset mid-operation: reset_n pulsed low at ROUND rc=5 -> outputs zero immediately, in_ready=1, no out_valid; a new ct then decrypts correctly.
REQ-034 SHALL pass back-to-back: 100 random ct from an encrypt model with out_ready=1 -> all pt match, with 12-cycle throughput.
